lane_word_serializer: RTL
=========================

Name: lane_word_serializer

Overview:
Parametrised word-to-slice serializer for the PCI physical-layer datapath. It accepts IN_W-bit words from NUM_LANES input lanes under a valid/ready handshake and grants lanes round-robin. Each granted word is emitted as RATIO = IN_W/OUT_W slices on a single OUT_W-bit stream, with output backpressure. It sits between the lane striping logic and the byte-wide line encoder, running on the fast clock.

Parameters:
IN_W, 32, input word width in bits.
OUT_W, 8, output slice width in bits. IN_W % OUT_W must be 0 and RATIO must be at least 2, checked at elaboration.
NUM_LANES, 4, number of input lanes (1..16).
LANE_ID_W, max(1, clog2(NUM_LANES)), width of the lane tag.

Ports:
clk_4f  input  1  fast clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
lane_data  input  NUM_LANES*IN_W  packed words; lane i occupies bits [i*IN_W +: IN_W].
lane_valid  input  NUM_LANES  per-lane word valid.
lane_ready  output  NUM_LANES  per-lane accept; at most one bit high per cycle.
msb_first  input  1  slice order mode: 1 = [IN_W-1 -: OUT_W] first, 0 = [OUT_W-1:0] first. Sampled only when a word is loaded.
out_ready  input  1  downstream accept.
data_out  output  OUT_W  current slice.
valid_out  output  1  data_out valid.
lane_id_out  output  LANE_ID_W  source lane of the current word.
sof_out  output  1  high on the first slice of a word.
eof_out  output  1  high on the last slice of a word.

Behaviour:
- State: hold_q (IN_W), order_q, lane_q, idx_q (slice counter 0..RATIO-1), busy_q, rr_ptr_q.
- Reset (reset=1 at an edge):
  - all registers cleared; rr_ptr_q = 0.
  - data_out=0, valid_out=0, lane_id_out=0, sof_out=0, eof_out=0.
  - lane_ready=0 while reset is high.
  - An in-flight word is discarded, not resumed.
- Outputs come from registers only; there is no combinational path from inputs to the data_out, valid_out, sof_out, eof_out or lane_id_out outputs.
  - valid_out = busy_q.
  - data_out = slice idx_q of hold_q in order order_q.
  - sof_out = busy_q & (idx_q==0).
  - eof_out = busy_q & (idx_q==RATIO-1).
- Slice transfer: a slice is accepted when valid_out & out_ready.
  - On accept with idx_q < RATIO-1, idx_q increments.
  - While out_ready=0, every output holds stable and idx_q does not change.
- Load window: load_ok = ~busy_q | (eof_out & out_ready).
- Arbitration and load:
  - When load_ok and any lane_valid is high, the round-robin arbiter grants exactly one lane.
  - The search starts at rr_ptr_q and wraps at NUM_LANES.
  - lane_ready = grant one-hot when load_ok, else 0. lane_ready may depend combinationally on lane_valid.
  - On the load edge: hold_q <= granted word, lane_q <= grant index, order_q <= msb_first, idx_q <= 0, busy_q <= 1, rr_ptr_q <= (grant+1) mod NUM_LANES.
- Load window with no lane valid: if eof is accepted, busy_q <= 0 and idx_q <= 0. If idle, the block stays idle.
- Latency: a word accepted at edge N presents its first slice after edge N, in cycle N+1.
- Throughput: with out_ready held at 1 and lanes valid, the output produces RATIO slices per word back to back, with no bubble between words.
- Simultaneous eof accept and new load: the new word's first slice follows immediately. valid_out stays high and sof_out rises in the next cycle.
- Lanes with lane_valid high and lane_ready low must hold their data; the block never drops or duplicates a word.
- A change to msb_first mid-word has no effect until the next load.
- NUM_LANES=1: the arbiter degenerates to a pass-through and rr_ptr_q stays 0.

Decomposition:
- Shared package pci_phy_pkg: the clog2-based LANE_ID_W helper, slice-order constants ORDER_LSB=0 and ORDER_MSB=1, and the elaboration check macro for IN_W % OUT_W.
- One sub-module, rr_arbiter.
  - Parameter: N.
  - Inputs: req[N], ptr, en.
  - Outputs: gnt one-hot, gnt_idx, any.
  - Purely combinational.
  - Instantiated once.
  - Testable standalone.

Test Plan:
- Reset then a single word: NUM_LANES=4, lane 2 valid with 0xA1B2C3D4, msb_first=1, out_ready=1.
  - lane_ready[2] pulses for 1 cycle.
  - data_out = A1, B2, C3, D4 in cycles N+1..N+4.
  - sof_out on A1, eof_out on D4, lane_id_out=2, then valid_out=0.
- LSB mode: same word with msb_first=0.
  - data_out = D4, C3, B2, A1.
- Round robin, back to back: all 4 lanes valid continuously, lane i data = 0x11111111*(i+1), out_ready=1.
  - Grants in order 0,1,2,3,0.
  - valid_out stays high for 16 consecutive cycles.
  - sof_out every 4th cycle.
  - lane_id_out sequence 0,1,2,3.
- Backpressure: during word 0xDEADBEEF, drop out_ready for 3 cycles after BE.
  - data_out, valid_out and eof_out stay frozen on BE.
  - No lane_ready during the stall.
  - EF follows once out_ready returns.
- Reset mid-word: assert reset after the second slice.
  - Next cycle: all outputs 0, rr_ptr reset.
  - The next load after release grants the lowest valid lane starting from lane 0.
- Parameter sweep: IN_W=64, OUT_W=16, NUM_LANES=3, word 0x0123456789ABCDEF, msb_first=1.
  - Slices 0123, 4567, 89AB, CDEF.
  - The lane pointer wraps 2→0.

Source files
------------

// File: rtl/pci_phy_pkg.sv
// pci_phy_pkg: definitions shared across the PCI physical-layer datapath.
//   ORDER_LSB / ORDER_MSB : slice-order encodings carried alongside a held word.
//   lane_id_w()           : width of a lane tag for a given lane count (min 1).
//   PCI_PHY_CHECK_SLICING : elaboration guard that a word splits into two or
//                           more whole slices; expands to a generate-if.

`ifndef PCI_PHY_PKG_SV
`define PCI_PHY_PKG_SV

`define PCI_PHY_CHECK_SLICING(in_w, out_w) \
  if ((((in_w) % (out_w)) != 0) || (((in_w) / (out_w)) < 2)) begin : g_bad_slicing \
    $error("IN_W must be a multiple of OUT_W giving at least two slices"); \
  end

package pci_phy_pkg;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  function automatic int lane_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req     : request per requester
//   ptr     : requester index with highest priority this cycle
//   en      : grant enable; when low no grant is issued
//   gnt     : one-hot grant
//   gnt_idx : binary index of the granted requester
//   any     : a grant is being issued

module rr_arbiter
  import pci_phy_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = lane_id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Two ordered passes give the wrapped search: first the lowest requester at
  // or above ptr, otherwise the lowest one below ptr.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && (j >= int'(ptr))) begin
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
        any     = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && (j < int'(ptr))) begin
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
        any     = 1'b1;
      end
    end
    if (!en) begin
      gnt = '0;
      any = 1'b0;
    end
  end

endmodule

// File: rtl/lane_word_serializer.sv
// lane_word_serializer: accepts IN_W-bit words from NUM_LANES lanes (round-robin
// grant, valid/ready) and emits each as IN_W/OUT_W slices on one OUT_W stream.
//   clk_4f      : fast clock, rising edge
//   reset       : synchronous, active-high
//   lane_data   : packed lane words, lane i at [i*IN_W +: IN_W]
//   lane_valid  : per-lane word valid
//   lane_ready  : per-lane accept, one-hot or zero
//   msb_first   : slice order for the next loaded word (1 = top slice first)
//   out_ready   : downstream accept
//   data_out    : current slice
//   valid_out   : data_out valid
//   lane_id_out : source lane of the current word
//   sof_out     : first slice of a word
//   eof_out     : last slice of a word

module lane_word_serializer
  import pci_phy_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int NUM_LANES = 4,
  parameter int LANE_ID_W = lane_id_w(NUM_LANES)
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic [NUM_LANES*IN_W-1:0] lane_data,
  input  logic [NUM_LANES-1:0]      lane_valid,
  output logic [NUM_LANES-1:0]      lane_ready,
  input  logic                      msb_first,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          data_out,
  output logic                      valid_out,
  output logic [LANE_ID_W-1:0]      lane_id_out,
  output logic                      sof_out,
  output logic                      eof_out
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = (RATIO <= 2) ? 1 : $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  `PCI_PHY_CHECK_SLICING(IN_W, OUT_W)

  if ((NUM_LANES < 1) || (NUM_LANES > 16)) begin : g_bad_lanes
    $error("NUM_LANES must be in 1..16");
  end

  // Slice k of w; MSB order walks down from the top, LSB order up from bit 0.
  function automatic logic [OUT_W-1:0] slice_sel(input logic [IN_W-1:0]  w,
                                                 input logic [IDX_W-1:0] k,
                                                 input logic             order);
    logic [IN_W-1:0] t;
    if (order == ORDER_MSB) begin
      t = w << (int'(k) * OUT_W);
      return t[IN_W-1 -: OUT_W];
    end else begin
      t = w >> (int'(k) * OUT_W);
      return t[OUT_W-1:0];
    end
  endfunction

  logic [IN_W-1:0]      hold_q, hold_d;
  logic                 order_q, order_d;
  logic [LANE_ID_W-1:0] lane_q, lane_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic [LANE_ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_LANES-1:0] gnt;
  logic [LANE_ID_W-1:0] gnt_idx;
  logic                 gnt_any;
  logic                 load_ok;
  logic [IN_W-1:0]      word_sel;

  assign valid_out   = busy_q;
  assign data_out    = slice_sel(hold_q, idx_q, order_q);
  assign lane_id_out = lane_q;
  assign sof_out     = busy_q & (idx_q == '0);
  assign eof_out     = busy_q & (idx_q == LAST_IDX);

  // A new word may load while idle or on the same edge the last slice leaves.
  assign load_ok = ~busy_q | (eof_out & out_ready);

  rr_arbiter #(
    .N  (NUM_LANES),
    .IW (LANE_ID_W)
  ) u_arb (
    .req     (lane_valid),
    .ptr     (rr_ptr_q),
    .en      (load_ok & ~reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign lane_ready = gnt;

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (gnt[i]) word_sel = lane_data[i*IN_W +: IN_W];
    end
  end

  always_comb begin
    hold_d   = hold_q;
    order_d  = order_q;
    lane_d   = lane_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;

    if (busy_q && out_ready && (idx_q != LAST_IDX)) idx_d = idx_q + 1'b1;

    if (load_ok) begin
      if (gnt_any) begin
        hold_d   = word_sel;
        lane_d   = gnt_idx;
        order_d  = msb_first;
        idx_d    = '0;
        busy_d   = 1'b1;
        rr_ptr_d = (gnt_idx == LANE_ID_W'(NUM_LANES - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        busy_d = 1'b0;
        idx_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      hold_q   <= '0;
      order_q  <= 1'b0;
      lane_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      hold_q   <= hold_d;
      order_q  <= order_d;
      lane_q   <= lane_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
